// File: rtl/voice_allocator_pkg.sv
// Shared types and default widths for the polyphonic voice allocator.
package voice_allocator_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_e;

  localparam int DEF_NUM_VOICES = 8;
  localparam int DEF_NOTE_W     = 7;
  localparam int DEF_VEL_W      = 7;
  localparam int DEF_AGE_W      = 8;
endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake: the sequencer side is master, the allocator is slave.
interface voice_allocator_if #(
  parameter int NOTE_W = 7,
  parameter int VEL_W  = 7
);
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;
  logic [VEL_W-1:0]  ev_vel;

  modport master (output ev_valid, ev_on, ev_note, ev_vel, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_note, ev_vel, output ev_ready);
endinterface

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters plus a running "oldest voice" compare
// fed one voice index per scan cycle.
module voice_age_tracker
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = DEF_AGE_W,
  parameter int IDX_W      = 3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  input  logic             commit_on,
  input  logic [IDX_W-1:0] target,
  input  logic             scan_en,
  input  logic [IDX_W-1:0] scan_idx,
  output logic [IDX_W-1:0] oldest_idx
);
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q;
  logic [AGE_W-1:0]                 best_age;
  logic [AGE_W-1:0]                 scan_age;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_age
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          age_q[g] <= '0;
      else if (clr_all)                  age_q[g] <= '0;
      else if (commit_on) begin
        if (target == IDX_W'(g))         age_q[g] <= '0;
        else if (age_q[g] != '1)         age_q[g] <= age_q[g] + 1'b1;
      end
    end
  end

  assign scan_age = age_q[scan_idx];

  // Index 0 seeds the compare; strict '>' keeps ties on the lowest index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_age   <= '0;
      oldest_idx <= '0;
    end else if (scan_en && (scan_idx == '0 || scan_age > best_age)) begin
      best_age   <= scan_age;
      oldest_idx <= scan_idx;
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: sequential scan over voices, then one commit
// that retriggers a matching voice, takes a free one, or steals the oldest.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int VEL_W      = DEF_VEL_W,
  parameter int AGE_W      = DEF_AGE_W
)(
  input  logic                         clk,
  input  logic                         rst,
  voice_allocator_if.slave             ev,
  input  logic                         all_off,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic                         steal
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_e state_q, state_d;

  logic                             accept, last_scan, commit_ok, commit_on;
  logic                             cap_on;
  logic [NOTE_W-1:0]                cap_note;
  logic [VEL_W-1:0]                 cap_vel;
  logic [IDX_W-1:0]                 scan_idx, match_idx, free_idx, oldest_idx, target;
  logic                             match_found, free_found;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q;
  logic [NUM_VOICES-1:0][VEL_W-1:0]  vel_q;
  logic [NUM_VOICES-1:0]            gate_q;

  assign accept    = ev.ev_valid && ev.ev_ready;
  assign last_scan = (scan_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (all_off) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:   if (accept)    state_d = ST_SCAN;
        ST_SCAN:   if (last_scan) state_d = ST_COMMIT;
        ST_COMMIT:                state_d = ST_IDLE;
        default:                  state_d = ST_IDLE;
      endcase
    end
  end

  // Panic wins even over a same-cycle handshake or commit.
  always_comb begin
    ev.ev_ready = 1'b0;
    commit_ok   = 1'b0;
    case (state_q)
      ST_IDLE:   ev.ev_ready = !all_off;
      ST_COMMIT: commit_ok   = !all_off;
      default:   ;
    endcase
  end

  assign commit_on = commit_ok && cap_on;
  assign target    = match_found ? match_idx : (free_found ? free_idx : oldest_idx);

  always_comb begin
    voice_trig = '0;
    steal      = 1'b0;
    if (commit_on) begin
      voice_trig[target] = 1'b1;
      steal              = !match_found && !free_found;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_on      <= 1'b0;
      cap_note    <= '0;
      cap_vel     <= '0;
      scan_idx    <= '0;
      match_idx   <= '0;
      free_idx    <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      note_q      <= '0;
      vel_q       <= '0;
      gate_q      <= '0;
    end else if (all_off) begin
      gate_q   <= '0;
      scan_idx <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          // Velocity-zero note-on is a note-off.
          cap_on      <= ev.ev_on && (ev.ev_vel != '0);
          cap_note    <= ev.ev_note;
          cap_vel     <= ev.ev_vel;
          scan_idx    <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
        end
        ST_SCAN: begin
          if (!match_found && gate_q[scan_idx] && note_q[scan_idx] == cap_note) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!free_found && !gate_q[scan_idx]) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          scan_idx <= last_scan ? '0 : scan_idx + 1'b1;
        end
        ST_COMMIT: begin
          if (cap_on) begin
            note_q[target] <= cap_note;
            vel_q[target]  <= cap_vel;
            gate_q[target] <= 1'b1;
          end else if (match_found) begin
            gate_q[match_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_age (
    .clk        (clk),
    .rst        (rst),
    .clr_all    (all_off),
    .commit_on  (commit_on),
    .target     (target),
    .scan_en    (state_q == ST_SCAN),
    .scan_idx   (scan_idx),
    .oldest_idx (oldest_idx)
  );

  assign voice_note = note_q;
  assign voice_vel  = vel_q;
  assign voice_gate = gate_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Randomized and directed checks of voice_allocator against an array-based
// reference model of the voice pool.
module tb_voice_allocator;
  localparam int NV = 8;
  localparam int NW = 7;
  localparam int VW = 7;
  localparam int AW = 8;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic             clk;
  logic             rst;
  logic             all_off;
  logic [NV*NW-1:0] voice_note;
  logic [NV*VW-1:0] voice_vel;
  logic [NV-1:0]    voice_gate;
  logic [NV-1:0]    voice_trig;
  logic             steal;

  voice_allocator_if #(.NOTE_W(NW), .VEL_W(VW)) ev_if ();

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .VEL_W(VW), .AGE_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ev         (ev_if),
    .all_off    (all_off),
    .voice_note (voice_note),
    .voice_vel  (voice_vel),
    .voice_gate (voice_gate),
    .voice_trig (voice_trig),
    .steal      (steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int steal_seen = 0;

  int m_gate [NV];
  int m_note [NV];
  int m_vel  [NV];
  int m_age  [NV];

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_all_off();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_age[i] = 0;
    end
  endtask

  // Reference: match, else lowest free, else oldest (ties lowest index).
  task automatic model_apply(input bit on, input int note, input int vel,
                             output logic [NV-1:0] trig, output bit stl);
    int t;
    int best;
    t = -1; trig = '0; stl = 0;
    for (int i = 0; i < NV; i++)
      if (t < 0 && m_gate[i] != 0 && m_note[i] == note) t = i;
    if (on && vel != 0) begin
      if (t < 0)
        for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] == 0) t = i;
      if (t < 0) begin
        best = -1;
        for (int i = 0; i < NV; i++)
          if (m_age[i] > best) begin best = m_age[i]; t = i; end
        stl = 1;
      end
      for (int i = 0; i < NV; i++)
        m_age[i] = (i == t) ? 0 : ((m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1);
      m_note[t] = note; m_vel[t] = vel; m_gate[t] = 1;
      trig[t] = 1'b1;
    end else if (t >= 0) begin
      m_gate[t] = 0;
    end
  endtask

  task automatic start_event(input bit on, input int note, input int vel);
    bit ok;
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ev_if.ev_ready === 1'b1) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ready_timeout: ev_ready=%b required 1 within 64 cycles", ev_if.ev_ready);
    end
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = on;
    ev_if.ev_note  = NW'(note);
    ev_if.ev_vel   = VW'(vel);
    @(posedge clk);
    #1;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = $urandom_range(0, 1);
    ev_if.ev_note  = NW'($urandom);
    ev_if.ev_vel   = VW'($urandom);
  endtask

  // Issue one event and check handshake, pulses and the resulting pool.
  task automatic run_event(input bit on, input int note, input int vel);
    logic [NV-1:0]    exp_trig;
    bit               exp_stl;
    logic [NV*NW-1:0] exp_n;
    logic [NV*VW-1:0] exp_v;
    logic [NV-1:0]    exp_g;
    model_apply(on, note, vel, exp_trig, exp_stl);
    start_event(on, note, vel);
    for (int k = 1; k <= NV + 1; k++) begin
      @(negedge clk);
      if (steal === 1'b1) steal_seen++;
      total++;
      if (ev_if.ev_ready !== 1'b0) begin
        bad++; $display("FAIL busy_ready k=%0d: got %b want 0", k, ev_if.ev_ready);
      end
      total++;
      if (k <= NV) begin
        if (voice_trig !== '0 || steal !== 1'b0) begin
          bad++; $display("FAIL scan_pulse k=%0d: trig=%h steal=%b want 0/0", k, voice_trig, steal);
        end
      end else begin
        if (voice_trig !== exp_trig || steal !== exp_stl) begin
          bad++; $display("FAIL commit_pulse note=%0d: trig=%h steal=%b want %h/%b",
                          note, voice_trig, steal, exp_trig, exp_stl);
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      exp_n[i*NW +: NW] = NW'(m_note[i]);
      exp_v[i*VW +: VW] = VW'(m_vel[i]);
      exp_g[i]          = (m_gate[i] != 0);
    end
    total++;
    if (ev_if.ev_ready !== 1'b1) begin
      bad++; $display("FAIL ready_return: got %b want 1", ev_if.ev_ready);
    end
    total++;
    if (voice_gate !== exp_g) begin
      bad++; $display("FAIL gate note=%0d: got %h want %h", note, voice_gate, exp_g);
    end
    total++;
    if (voice_note !== exp_n) begin
      bad++; $display("FAIL notes note=%0d: got %h want %h", note, voice_note, exp_n);
    end
    total++;
    if (voice_vel !== exp_v) begin
      bad++; $display("FAIL vels note=%0d: got %h want %h", note, voice_vel, exp_v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (voice_gate !== '0 || voice_note !== '0 || voice_vel !== '0) begin
      bad++; $display("FAIL reset_state: gate=%h note=%h vel=%h want 0", voice_gate, voice_note, voice_vel);
    end
    total++;
    if (voice_trig !== '0 || steal !== 1'b0 || ev_if.ev_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ctrl: trig=%h steal=%b ready=%b want 0/0/1", voice_trig, steal, ev_if.ev_ready);
    end
  endtask

  task automatic test_first_note();
    do_reset();
    run_event(1, 60, 100);
    total++;
    if (voice_gate[0] !== 1'b1 || voice_note[0 +: NW] !== NW'(60)) begin
      bad++; $display("FAIL first_note: gate0=%b note0=%0d want 1/60", voice_gate[0], voice_note[0 +: NW]);
    end
  endtask

  task automatic test_steal();
    do_reset();
    steal_seen = 0;
    for (int n = 60; n <= 68; n++) run_event(1, n, 80);
    total++;
    if (steal_seen !== 1 || voice_note[0 +: NW] !== NW'(68)) begin
      bad++; $display("FAIL steal_ninth: steals=%0d note0=%0d want 1/68", steal_seen, voice_note[0 +: NW]);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    run_event(1, 60, 100);
    run_event(1, 60, 50);
    total++;
    if (voice_vel[0 +: VW] !== VW'(50) || voice_gate[1] !== 1'b0) begin
      bad++; $display("FAIL retrigger: vel0=%0d gate1=%b want 50/0", voice_vel[0 +: VW], voice_gate[1]);
    end
  endtask

  task automatic test_note_off();
    do_reset();
    run_event(1, 60, 100);
    run_event(1, 60, 0);
    total++;
    if (voice_gate[0] !== 1'b0 || voice_note[0 +: NW] !== NW'(60)) begin
      bad++; $display("FAIL vel0_off: gate0=%b note0=%0d want 0/60", voice_gate[0], voice_note[0 +: NW]);
    end
    run_event(1, 61, 90);
    run_event(0, 72, 10);
    total++;
    if (voice_gate !== 8'h01 || voice_note[0 +: NW] !== NW'(61)) begin
      bad++; $display("FAIL absent_off: gate=%h note0=%0d want 01/61", voice_gate, voice_note[0 +: NW]);
    end
  endtask

  task automatic test_all_off();
    do_reset();
    run_event(1, 60, 100);
    run_event(1, 62, 100);
    start_event(1, 64, 100);
    repeat (3) @(posedge clk);
    #1 all_off = 1'b1;
    @(negedge clk);
    total++;
    if (voice_trig !== '0 || ev_if.ev_ready !== 1'b0) begin
      bad++; $display("FAIL panic_cycle: trig=%h ready=%b want 0/0", voice_trig, ev_if.ev_ready);
    end
    @(posedge clk);
    #1 all_off = 1'b0;
    model_all_off();
    @(negedge clk);
    total++;
    if (voice_gate !== '0 || voice_trig !== '0 || ev_if.ev_ready !== 1'b1) begin
      bad++; $display("FAIL panic_after: gate=%h trig=%h ready=%b want 0/0/1", voice_gate, voice_trig, ev_if.ev_ready);
    end
    run_event(1, 70, 30);
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    run_event(1, 55, 40);
    start_event(1, 57, 40);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if (voice_gate !== '0 || voice_note !== '0 || voice_vel !== '0 || voice_trig !== '0 || steal !== 1'b0) begin
      bad++; $display("FAIL async_reset: gate=%h note=%h vel=%h trig=%h steal=%b want 0",
                      voice_gate, voice_note, voice_vel, voice_trig, steal);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run_event(1, 64, 90);
    total++;
    if (voice_gate !== 8'h01 || voice_note[0 +: NW] !== NW'(64)) begin
      bad++; $display("FAIL post_reset_alloc: gate=%h note0=%0d want 01/64", voice_gate, voice_note[0 +: NW]);
    end
  endtask

  task automatic test_random();
    bit on;
    int note, vel;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        model_all_off();
        total++;
        if (voice_gate !== '0) begin
          bad++; $display("FAIL rand_panic: gate=%h want 0", voice_gate);
        end
      end
      on   = ($urandom_range(0, 3) != 0);
      note = $urandom_range(60, 71);
      vel  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
      run_event(on, note, vel);
    end
  endtask

  initial begin
    rst            = 1'b0;
    all_off        = 1'b0;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'b0;
    ev_if.ev_note  = '0;
    ev_if.ev_vel   = '0;
    model_reset();
    test_reset();
    test_first_note();
    test_steal();
    test_retrigger();
    test_note_off();
    test_all_off();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, the number of synth voices managed.
REQ-002 SHALL have parameter NOTE_W, default 7, the MIDI note number width.
REQ-003 SHALL have parameter VEL_W, default 7, the MIDI velocity width.
REQ-004 SHALL have parameter AGE_W, default 8, the per-voice age counter width.
REQ-005 clk  input  1  sole clock; all state rising-edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 ev_valid  input  1  note event present.
REQ-008 ev_ready  output  1  allocator accepts event this cycle.
REQ-009 ev_on  input  1  1 = note-on, 0 = note-off.
REQ-010 ev_note  input  NOTE_W  MIDI note number.
REQ-011 ev_vel  input  VEL_W  MIDI velocity.
REQ-012 all_off  input  1  panic: clear every gate.
REQ-013 voice_note  output  NUM_VOICES*NOTE_W  packed per-voice note; voice i at bits [i*NOTE_W +: NOTE_W].
REQ-014 voice_vel  output  NUM_VOICES*VEL_W  packed per-voice velocity, same packing.
REQ-015 voice_gate  output  NUM_VOICES  voice i held (note sounding).
REQ-016 voice_trig  output  NUM_VOICES  one-cycle pulse: voice i (re)started.
REQ-017 steal  output  1  one-cycle pulse: the commit reassigned a gated voice.

Function
REQ-018 SHALL implement FSM IDLE -> SCAN -> COMMIT -> IDLE; ev_ready SHALL be 1 only in IDLE.
REQ-019 SHALL capture ev_on/note/vel in IDLE when ev_valid && ev_ready, then enter SCAN.
REQ-020 SHALL treat note-on with ev_vel == 0 as note-off.
REQ-021 SCAN SHALL examine one voice index per cycle, 0..NUM_VOICES-1, for exactly NUM_VOICES cycles, then enter COMMIT.
REQ-022 During SCAN it SHALL record: match = gated voice whose note equals the captured note; free = lowest-index voice with gate 0; oldest = voice with the largest age, ties to lowest index.
REQ-023 Note-on commit target SHALL be match if found, else free if found, else oldest.
REQ-024 Note-on commit SHALL load note/vel into the target, set its gate, pulse its voice_trig, zero its age, and increment every other voice's age, saturating at 2^AGE_W-1.
REQ-025 steal SHALL pulse in COMMIT only when the target came from the oldest path.
REQ-026 Note-off commit SHALL clear the gate of match; without a match, no state changes and no pulses.
REQ-027 Note-off SHALL leave voice_note/voice_vel unchanged, so the release stage keeps its pitch.
REQ-028 Latency: accept at cycle t, outputs updated at the edge ending cycle t+NUM_VOICES+1, ev_ready high again at t+NUM_VOICES+2.
REQ-029 all_off SHALL clear all gates and ages, abort any SCAN/COMMIT without applying it, and return to IDLE; it has priority over everything else, and the aborted event is dropped.
REQ-030 voice_trig and steal SHALL be 0 in every non-COMMIT cycle.
REQ-031 Event inputs SHALL be ignored while ev_ready is 0.

Reset
REQ-032 On rst low, SHALL asynchronously set FSM to IDLE and clear every voice_note, voice_vel, voice_gate, voice_trig, steal, and age; ev_ready SHALL be 1 after release.
REQ-033 Reset mid-SCAN SHALL discard the captured event.

Structure
REQ-034 Shared package SHALL hold the FSM state enum and the default NOTE_W, VEL_W, and AGE_W constants.
REQ-035 A sub-module voice_age_tracker (per-voice saturating age counters, plus oldest-index compare per scanned voice) is natural; the remaining logic stays in voice_allocator.

Verification
REQ-036 After reset, note-on 60 vel 100: voice 0 gate=1, note=60, trig[0] pulse at cycle t+9 (NUM_VOICES=8); ev_ready=0 for 9 cycles.
REQ-037 Nine note-ons 60..68 without note-offs: the ninth steals voice 0 (note 68), and steal pulses once.
REQ-038 Note-on 60 twice (vel 100, then 50): voice 0 is retriggered with vel=50, and voice 1 stays free.
REQ-039 Note-on 60 then note-on 60 vel 0: voice 0 gate=0, note stays 60; a note-off for absent note 72 causes no change.
REQ-040 all_off asserted in the 4th SCAN cycle: all gates=0, no trig, ev_ready=1 the next cycle.
REQ-041 rst asserted mid-SCAN: all outputs zero immediately; the next event is allocated to voice 0.
